// File: rtl/time_scheduler.sv
// Emulated-time sequencer: scans requesters for the earliest pending event and advances time to it.
// Issue latency NUM_REQ+2 cycles from IDLE; each advance is clamped to DT_MAX, followed by SETTLE idle cycles.
module time_scheduler #(
    parameter int                     NUM_REQ    = 2,
    parameter int                     TIME_WIDTH = 40,
    parameter logic [TIME_WIDTH-1:0]  DT_MAX     = TIME_WIDTH'(2**20 - 1),
    parameter int                     SETTLE     = 3
) (
    input  logic                           clk_sys,
    input  logic                           rst,
    input  logic                           run,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TIME_WIDTH-1:0]  req_time,
    output logic [TIME_WIDTH-1:0]          time_next,
    output logic [NUM_REQ-1:0]             time_eq,
    output logic                           step,
    output logic                           busy,
    output logic                           err_past
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TIME_WIDTH-1:0]  min_t_q, min_t_d;
    logic [TIME_WIDTH-1:0]  time_q, time_d;
    logic [NUM_REQ-1:0]     eq_q, eq_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [TIME_WIDTH-1:0]  req_t [NUM_REQ];
    logic [TIME_WIDTH-1:0]  cur_t;
    logic                   cur_vld;
    logic [TIME_WIDTH-1:0]  dt;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_t[k] = req_time[k*TIME_WIDTH +: TIME_WIDTH];
    end

    assign cur_t   = req_t[idx_q];
    assign cur_vld = req_valid[idx_q];
    assign dt      = min_t_q - time_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        min_t_d = min_t_q;
        time_d  = time_q;
        eq_d    = '0;
        step_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (run && |req_valid) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    min_t_d = '1;
                end
            end
            SCAN: begin
                // A past-time request pins the minimum to now, giving a dt=0 issue.
                if (cur_vld && cur_t < time_q) begin
                    err_d   = 1'b1;
                    min_t_d = time_q;
                end else if (cur_vld && cur_t < min_t_q) begin
                    min_t_d = cur_t;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ISSUE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ISSUE: begin
                step_d  = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = WAIT;
                if (dt > DT_MAX) begin
                    time_d = time_q + DT_MAX;
                end else begin
                    time_d = min_t_q;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        eq_d[k] = req_valid[k] && (req_t[k] <= min_t_q);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            min_t_q <= '1;
            time_q  <= '0;
            eq_q    <= '0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            min_t_q <= min_t_d;
            time_q  <= time_d;
            eq_q    <= eq_d;
            step_q  <= step_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign time_next = time_q;
    assign time_eq   = eq_q;
    assign step      = step_q;
    assign err_past  = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_time_scheduler.sv
// Directed bench for time_scheduler: table of single issues plus reset, clamp and idle sequences.
module tb_time_scheduler;

    localparam int NR = 2;
    localparam int TW = 40;

    logic           clk_sys;
    logic           rst;
    logic           run;
    logic [NR-1:0]  req_valid;
    logic [NR*TW-1:0] req_time;
    logic [TW-1:0]  time_next;
    logic [NR-1:0]  time_eq;
    logic           step;
    logic           busy;
    logic           err_past;

    time_scheduler #(
        .NUM_REQ    (NR),
        .TIME_WIDTH (TW),
        .DT_MAX     (40'd1000),
        .SETTLE     (3)
    ) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .run       (run),
        .req_valid (req_valid),
        .req_time  (req_time),
        .time_next (time_next),
        .time_eq   (time_eq),
        .step      (step),
        .busy      (busy),
        .err_past  (err_past)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    typedef struct {
        logic [1:0]  vld;
        logic [39:0] t0;
        logic [39:0] t1;
        logic [39:0] exp_time;
        logic [1:0]  exp_eq;
        logic        exp_err;
    } vec_t;

    vec_t tbl [6];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (!busy) ok = 1'b1;
            else tick();
        end
        if (!ok) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Start from IDLE, expect one issue exactly NUM_REQ+2 edges later, then a single-cycle pulse.
    task automatic apply(input vec_t v, input string tag);
        bit found = 1'b0;
        int n = 0;
        wait_idle();
        req_valid = v.vld;
        req_time  = {v.t1, v.t0};
        run       = 1'b1;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (step) begin
                found = 1'b1;
                n = i;
            end
        end
        run = 1'b0;
        chk({tag, "_step_seen"}, 64'(found), 64'd1);
        if (found) begin
            chk({tag, "_latency"}, 64'(n), 64'd4);
            chk({tag, "_time_next"}, 64'(time_next), 64'(v.exp_time));
            chk({tag, "_time_eq"}, 64'(time_eq), 64'(v.exp_eq));
            chk({tag, "_err_past"}, 64'(err_past), 64'(v.exp_err));
            tick();
            chk({tag, "_pulse_clear"}, 64'({step, time_eq}), 64'd0);
        end
    endtask

    initial begin
        vec_t v;
        int   nstep;
        int   cnt_a;
        int   cnt_b;
        logic [39:0] st_time [3];
        logic [1:0]  st_eq   [3];
        int          st_cyc  [3];

        tbl[0] = '{2'b11, 40'd100, 40'd250,  40'd100, 2'b01, 1'b0};
        tbl[1] = '{2'b11, 40'd400, 40'd250,  40'd250, 2'b10, 1'b0};
        tbl[2] = '{2'b11, 40'd500, 40'd500,  40'd500, 2'b11, 1'b0};
        tbl[3] = '{2'b01, 40'd500, 40'd0,    40'd500, 2'b01, 1'b0};
        tbl[4] = '{2'b10, 40'd0,   40'd900,  40'd900, 2'b10, 1'b0};
        tbl[5] = '{2'b11, 40'd50,  40'd1200, 40'd900, 2'b01, 1'b1};

        rst       = 1'b1;
        run       = 1'b0;
        req_valid = '0;
        req_time  = '0;
        tick();
        tick();
        chk("rst_time_next", 64'(time_next), 64'd0);
        chk("rst_time_eq",   64'(time_eq),   64'd0);
        chk("rst_step",      64'(step),      64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_err_past",  64'(err_past),  64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset mid-SCAN with non-zero time and sticky error set.
        wait_idle();
        req_valid = 2'b11;
        req_time  = {40'd700, 40'd600};
        run       = 1'b1;
        tick();
        chk("midscan_busy", 64'(busy), 64'd1);
        chk("midscan_err_before", 64'(err_past), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midscan_rst_time_next", 64'(time_next), 64'd0);
        chk("midscan_rst_time_eq",   64'(time_eq),   64'd0);
        chk("midscan_rst_step",      64'(step),      64'd0);
        chk("midscan_rst_busy",      64'(busy),      64'd0);
        chk("midscan_rst_err_past",  64'(err_past),  64'd0);
        run       = 1'b0;
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        // Clamped advance: 0 -> 1000 -> 2000 -> 2500, period NUM_REQ+2+SETTLE.
        for (int i = 0; i < 3; i++) begin
            st_time[i] = '0;
            st_eq[i]   = 2'b11;
            st_cyc[i]  = 0;
        end
        nstep     = 0;
        req_valid = 2'b01;
        req_time  = {40'd0, 40'd2500};
        run       = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (step) begin
                if (nstep < 3) begin
                    st_time[nstep] = time_next;
                    st_eq[nstep]   = time_eq;
                    st_cyc[nstep]  = c;
                end
                nstep++;
                if (nstep == 3) req_valid = '0;
            end
        end
        run = 1'b0;
        chk("clamp_step_count", 64'(nstep), 64'd3);
        chk("clamp_t0", 64'(st_time[0]), 64'd1000);
        chk("clamp_t1", 64'(st_time[1]), 64'd2000);
        chk("clamp_t2", 64'(st_time[2]), 64'd2500);
        chk("clamp_eq0", 64'(st_eq[0]), 64'd0);
        chk("clamp_eq1", 64'(st_eq[1]), 64'd0);
        chk("clamp_eq2", 64'(st_eq[2]), 64'd1);
        chk("clamp_first_latency", 64'(st_cyc[0]), 64'd3);
        chk("clamp_period", 64'(st_cyc[1] - st_cyc[0]), 64'd7);

        // dt exactly DT_MAX issues directly; DT_MAX+1 takes one clamped step.
        v = '{2'b01, 40'd3500, 40'd0, 40'd3500, 2'b01, 1'b0};
        apply(v, "dtmax_exact");
        v = '{2'b01, 40'd4501, 40'd0, 40'd4500, 2'b00, 1'b0};
        apply(v, "dtmax_plus1_a");
        v = '{2'b01, 40'd4501, 40'd0, 40'd4501, 2'b01, 1'b0};
        apply(v, "dtmax_plus1_b");

        // Idle gating: run low with valid requests, then run high with none valid.
        wait_idle();
        cnt_a     = 0;
        cnt_b     = 0;
        run       = 1'b0;
        req_valid = 2'b11;
        req_time  = {40'd5000, 40'd5000};
        for (int c = 0; c < 10; c++) begin
            tick();
            if (step || busy) cnt_a++;
        end
        run       = 1'b1;
        req_valid = 2'b00;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (step || busy || time_eq != 0) cnt_b++;
        end
        run = 1'b0;
        chk("idle_run_low_activity", 64'(cnt_a), 64'd0);
        chk("idle_no_valid_activity", 64'(cnt_b), 64'd0);
        chk("idle_time_held", 64'(time_next), 64'd4501);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
